// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the ID-stage branch resolver: default widths and FSM encoding.
package branch_resolver_pkg;

  localparam int BR_WORD_SIZE = 16;
  localparam int BR_SAT_W     = 16;

  typedef enum logic {
    BR_RUN     = 1'b0,
    BR_RECOVER = 1'b1
  } br_state_t;

endpackage

// File: rtl/br_sat_counter.sv
// Saturating up-counter; one cycle from inc to count, sticks at all-ones until reset.
module br_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks the BTB prediction carried into ID against the resolved outcome; flush/redirect/update are same-cycle.
// Stall freezes ID and suppresses evaluation; optional BR_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int W = BR_WORD_SIZE
`ifdef BR_STATS_EN
  , parameter int SAT_W = BR_SAT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [W-1:0]     if_pc,
  input  logic [W-1:0]     if_btb_pc,
  input  logic             if_btb_taken,
  input  logic             stall,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_bcond,
  input  logic [W-1:0]     id_target,
  output logic [W-1:0]     id_pc,
  output logic             flush,
  output logic             redirect_valid,
  output logic [W-1:0]     redirect_pc,
  output logic             upd_valid,
  output logic [W-1:0]     upd_pc,
  output logic [W-1:0]     upd_target,
  output logic             upd_taken
`ifdef BR_STATS_EN
  , output logic [SAT_W-1:0] branch_count
  , output logic [SAT_W-1:0] mispredict_count
`endif
);

  logic         id_v;
  logic [W-1:0] id_pc_q;
  logic [W-1:0] pred_pc;
  logic         pred_taken;

  br_state_t    state, state_next;
  logic [W-1:0] act;
  logic         mis;

  always_comb begin
    act = ((id_branch & id_bcond) | id_jump) ? id_target
                                             : id_pc_q + {{(W-1){1'b0}}, 1'b1};
    // Covers BTB aliases too: a non-branch predicted taken mismatches pc+1.
    mis = id_v & ~stall & (state == BR_RUN) & (pred_pc != act);
  end

  always_comb begin
    flush          = mis;
    redirect_valid = mis;
    redirect_pc    = mis ? act : '0;
    upd_valid      = id_v & ~stall & (id_branch | id_jump);
    upd_pc         = id_pc_q;
    // These follow raw ID inputs, so gate them to keep outputs quiet in reset.
    upd_taken      = ~reset & (id_jump | id_bcond);
    upd_target     = reset ? '0 : id_target;
    id_pc          = id_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_v       <= 1'b0;
      id_pc_q    <= '0;
      pred_pc    <= '0;
      pred_taken <= 1'b0;
    end else if (stall) begin
      id_v       <= id_v;
    end else if (mis) begin
      id_v       <= 1'b0;
    end else begin
      id_v       <= if_valid;
      id_pc_q    <= if_pc;
      pred_pc    <= if_btb_pc;
      pred_taken <= if_btb_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BR_RUN;
    end else begin
      state <= state_next;
    end
  end

  // RECOVER spans the flushed slot so a single mispredict can never redirect twice.
  always_comb begin
    state_next = state;
    case (state)
      BR_RUN:     if (mis)    state_next = BR_RECOVER;
      BR_RECOVER: if (!stall) state_next = BR_RUN;
      default:                state_next = BR_RUN;
    endcase
  end

`ifdef BR_STATS_EN
  br_sat_counter #(.W(SAT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (upd_valid),
    .count (branch_count)
  );

  br_sat_counter #(.W(SAT_W)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mis),
    .count (mispredict_count)
  );
`endif

endmodule
